// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   symbol_edge_time() : clock cycles per UART symbol (integer division)
//   FRAME_LEN          : symbols in an 8N1 frame (start + 8 data + stop)
//   uart_state_t       : FSM state encodings common to TX and RX
package uart_pkg;

    localparam int unsigned FRAME_LEN = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } uart_state_t;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator: a free-running symbol-period counter.
//   clk   : clock, posedge
//   rst   : synchronous active-high reset, counter to 0
//   clear : holds the counter at 0 (phase-aligns the next symbol)
//   tick  : high in the last cycle of each symbol period while not cleared
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CntW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SymbolEdgeTime - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops bytes from a registered-output fifo and sends 8N1 frames.
//   clk        : clock, posedge
//   rst        : synchronous active-high reset; aborts any frame in flight
//   fifo_empty : fifo empty flag
//   fifo_rd_en : single-cycle read strobe, only in IDLE while the fifo is non-empty
//   fifo_dout  : fifo read data, valid the cycle after fifo_rd_en
//   serial_out : UART line, idles high, driven straight from a flop
//   busy       : high from the read strobe until the stop bit has completed
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  serial_out,
    output logic                  busy
);

    localparam int unsigned FrameW = DATA_WIDTH + 2;
    localparam int unsigned BitW   = $clog2(FrameW);
    localparam logic [BitW-1:0] StopIdx = BitW'(DATA_WIDTH + 1);

    uart_state_t       state_q, state_d;
    logic [FrameW-1:0] shift_q, shift_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              baud_clear;
    logic              baud_tick;
    logic              rd_en;

    baud_tick_gen #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rd_en      = 1'b0;
        baud_clear = 1'b1;
        case (state_q)
            IDLE: begin
                // Gated by rst so no fifo entry is consumed while reset is held.
                rd_en = !fifo_empty && !rst;
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // fifo_dout is valid now, one cycle after the strobe.
                shift_d   = {1'b1, fifo_dout, 1'b0};
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                baud_clear = 1'b0;
                if (baud_tick) begin
                    // Shifting in ones leaves the register all ones, so the line idles high.
                    shift_d   = {1'b1, shift_q[FrameW-1:1]};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == StopIdx) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // shift_q[0] is a flop and stays 1 outside SHIFT, so the pin never glitches.
    assign serial_out = shift_q[0];
    assign fifo_rd_en = rd_en;
    assign busy       = (state_q != IDLE) || rd_en;

endmodule
